imem_loader: RTL and testbench

- Hardware program loader: the writer counterpart to the processor's instruction-memory read path.
- Accepts a byte stream through a valid/ready handshake and packs it into big-endian 32-bit MIPS words.
- Writes each word to consecutive instruction-memory word addresses from 0.
- Holds the processor in reset until the programmed word count has been written, then releases it.

---
 rtl/imem_loader.sv | 92 +++++++++
 tb/tb_imem_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into big-endian words, writes them to imem from address 0, then releases the cpu
// Ports:
//   clk, reset (sync, active-low)
//   start/num_words            : load request and program length in words
//   byte_valid/byte_data/byte_ready : byte stream handshake, MSB of each word first
//   imem_we/imem_addr/imem_wdata   : instruction-memory write port
//   cpu_reset, busy, done, error, words_written : status
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_written
);
    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
    localparam logic [ADDR_WIDTH:0] MAX_W = MAX_WORDS[ADDR_WIDTH:0];
    state_t state, state_nx;
    logic [1:0] byte_idx;
    logic [23:0] shift;
    logic [ADDR_WIDTH:0] target;
    logic [ADDR_WIDTH:0] ww_inc;
    logic idle_or_done;
    logic too_big;
    assign idle_or_done = (state == IDLE) || (state == DONE);
    assign too_big      = num_words > MAX_W;
    assign ww_inc       = words_written + (ADDR_WIDTH+1)'(1);
    always_comb begin
        state_nx   = state;
        byte_ready = state == COLLECT;
        imem_we    = state == WRITE;
        busy       = (state == COLLECT) || (state == WRITE);
        done       = state == DONE;
        cpu_reset  = state != DONE;
        case (state)
            IDLE, DONE: if (start && !too_big) state_nx = (num_words == '0) ? DONE : COLLECT;
            COLLECT:    if (byte_valid && byte_idx == 2'd3) state_nx = WRITE;
            WRITE:      state_nx = (ww_inc == target) ? DONE : COLLECT;
            default:    state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            byte_idx      <= '0;
            shift         <= '0;
            target        <= '0;
            imem_addr     <= '0;
            imem_wdata    <= '0;
            error         <= 1'b0;
            words_written <= '0;
        end else begin
            state <= state_nx;
            if (idle_or_done && start) begin
                if (too_big) begin
                    error <= 1'b1;
                end else begin
                    error         <= 1'b0;
                    words_written <= '0;
                    byte_idx      <= '0;
                    target        <= num_words;
                end
            end
            // address and data are captured with the last byte so they are
            // valid during WRITE and hold afterwards
            if (state == COLLECT && byte_valid) begin
                byte_idx <= byte_idx + 2'd1;
                shift    <= {shift[15:0], byte_data};
                if (byte_idx == 2'd3) begin
                    imem_addr  <= words_written[ADDR_WIDTH-1:0];
                    imem_wdata <= {shift, byte_data};
                end
            end
            if (state == WRITE) begin
                words_written <= ww_inc;
                byte_idx      <= '0;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader against a word-packing memory model
module tb_imem_loader;
    localparam int AW = 8;
    localparam int MAXW = 256;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic [AW:0] num_words = '0;
    logic byte_valid = 1'b0;
    logic [7:0] byte_data = '0;
    logic byte_ready, imem_we, cpu_reset, busy, done, error;
    logic [AW-1:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [AW:0] words_written;
    int checks = 0;
    int errors = 0;
    logic [7:0] src[$];
    logic [39:0] writes[$];
    logic [31:0] tb_mem[256];
    logic [31:0] ref_mem[256];
    logic [7:0] basic_bytes[8] = '{8'h8C, 8'h02, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h04};

    imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            writes.push_back({imem_addr, imem_wdata});
            tb_mem[imem_addr] = imem_wdata;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_src(input int n, input bit fixed);
        src.delete();
        for (int i = 0; i < 4 * n; i++) src.push_back(fixed ? basic_bytes[i % 8] : 8'($urandom));
    endtask

    task automatic do_load(input string name, input int n, input int gap, input bit poke, input bit fixed);
        int cycles = 0;
        int idx = 0;
        int gapcnt = 0;
        int bad = 0;
        int budget = 20 * n * (gap + 2) + 20;
        bit acc;
        logic [31:0] w;
        load_src(n, fixed);
        writes.delete();
        num_words = (AW+1)'(n);
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if ({busy, cpu_reset, done, error} !== 4'b1100) begin
            errors++;
            $display("FAIL %s start_status: got busy,cpu_reset,done,error=%b required 1100", name, {busy, cpu_reset, done, error});
        end
        while (done !== 1'b1 && cycles < budget) begin
            if (busy !== 1'b1 || cpu_reset !== 1'b1) bad++;
            byte_valid = (idx < src.size()) && gapcnt == 0;
            byte_data = byte_valid ? src[idx] : 8'($urandom);
            if (poke) begin
                start = (cycles % 3 == 1);
                num_words = (cycles % 2 == 0) ? '0 : (AW+1)'(MAXW + 1);
            end
            acc = byte_valid && byte_ready;
            tick;
            cycles++;
            if (acc) begin
                idx++;
                gapcnt = gap;
            end else if (gapcnt > 0) gapcnt--;
        end
        start = 1'b0;
        byte_valid = 1'b0;
        if (gap == 0) begin
            checks++;
            if (cycles != 5 * n) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles required %0d", name, cycles, 5 * n);
            end
        end
        checks++;
        if ({done, cpu_reset, busy, byte_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL %s final_status: got done,cpu_reset,busy,byte_ready=%b required 1000", name, {done, cpu_reset, busy, byte_ready});
        end
        checks++;
        if (words_written !== (AW+1)'(n)) begin
            errors++;
            $display("FAIL %s words_written: got %0d required %0d", name, words_written, n);
        end
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL %s error_flag: got %b required 0", name, error);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s busy_during_load: got %0d cycles with busy/cpu_reset low required 0", name, bad);
        end
        checks++;
        if (writes.size() != n) begin
            errors++;
            $display("FAIL %s write_count: got %0d required %0d", name, writes.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            w = {src[4*i], src[4*i+1], src[4*i+2], src[4*i+3]};
            ref_mem[i] = w;
            if (i < writes.size()) begin
                checks++;
                if (writes[i] !== {8'(i), w}) begin
                    errors++;
                    $display("FAIL %s write%0d: got addr/data %h required %h", name, i, writes[i], {8'(i), w});
                end
            end
        end
        tick;
        checks++;
        if ({imem_addr, imem_wdata} !== {8'(n - 1), ref_mem[n-1]}) begin
            errors++;
            $display("FAIL %s hold: got addr/data %h required %h", name, {imem_addr, imem_wdata}, {8'(n - 1), ref_mem[n-1]});
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) tick;
        checks++;
        if ({byte_ready, imem_we, busy, done, error, cpu_reset} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000001", {byte_ready, imem_we, busy, done, error, cpu_reset});
        end
        checks++;
        if ({imem_addr, imem_wdata, words_written} !== '0) begin
            errors++;
            $display("FAIL reset_values: got addr=%h data=%h ww=%0d required zeros", imem_addr, imem_wdata, words_written);
        end
        reset = 1'b1;
        repeat (2) tick;
        checks++;
        if ({done, busy, cpu_reset} !== 3'b001) begin
            errors++;
            $display("FAIL reset_idle: got done,busy,cpu_reset=%b required 001", {done, busy, cpu_reset});
        end
    endtask

    task automatic test_basic;
        do_load("basic", 2, 0, 0, 1);
    endtask

    task automatic test_throttled;
        do_load("throttled", 2, 3, 0, 1);
    endtask

    task automatic test_boundaries;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        writes.delete();
        num_words = '0;
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if ({done, cpu_reset, words_written} !== {2'b10, (AW+1)'(0)} || writes.size() != 0) begin
            errors++;
            $display("FAIL zero_words: got done=%b cpu_reset=%b ww=%0d writes=%0d required 1 0 0 0", done, cpu_reset, words_written, writes.size());
        end
        reset = 1'b0;
        tick;
        reset = 1'b1;
        num_words = (AW+1)'(MAXW + 1);
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if ({error, cpu_reset, busy, done, byte_ready} !== 5'b11000) begin
            errors++;
            $display("FAIL too_many: got error,cpu_reset,busy,done,byte_ready=%b required 11000", {error, cpu_reset, busy, done, byte_ready});
        end
        byte_valid = 1'b1;
        repeat (3) tick;
        byte_valid = 1'b0;
        checks++;
        if ({error, busy, done, byte_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL too_many_stays_idle: got error,busy,done,byte_ready=%b required 1000", {error, busy, done, byte_ready});
        end
        do_load("after_error", 1, 0, 0, 0);
        num_words = (AW+1)'(300);
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if ({error, done, cpu_reset, words_written} !== {3'b110, (AW+1)'(1)}) begin
            errors++;
            $display("FAIL error_in_done: got error=%b done=%b cpu_reset=%b ww=%0d required 1 1 0 1", error, done, cpu_reset, words_written);
        end
    endtask

    task automatic test_reset_mid_load;
        int idx = 0;
        int cycles = 0;
        bit acc;
        load_src(2, 1);
        writes.delete();
        num_words = (AW+1)'(2);
        start = 1'b1;
        tick;
        start = 1'b0;
        while (idx < 6 && cycles < 100) begin
            byte_valid = 1'b1;
            byte_data = src[idx];
            acc = byte_ready;
            tick;
            cycles++;
            if (acc) idx++;
        end
        byte_valid = 1'b0;
        ref_mem[0] = {src[0], src[1], src[2], src[3]};
        reset = 1'b0;
        tick;
        checks++;
        if ({byte_ready, imem_we, busy, done, error, cpu_reset} !== 6'b000001 || {imem_addr, imem_wdata, words_written} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got flags=%b addr=%h data=%h ww=%0d required 000001 and zeros", {byte_ready, imem_we, busy, done, error, cpu_reset}, imem_addr, imem_wdata, words_written);
        end
        reset = 1'b1;
        tick;
        checks++;
        if (tb_mem[0] !== 32'h8C020004 || writes.size() != 1) begin
            errors++;
            $display("FAIL mid_reset_mem: got mem0=%h writes=%0d required 8c020004 1", tb_mem[0], writes.size());
        end
        do_load("after_reset", 1, 0, 0, 0);
    endtask

    task automatic test_busy_start_reload;
        do_load("busy_poke", 3, 1, 1, 0);
        do_load("reload", 1, 0, 0, 0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 8; k++) begin
            do_load($sformatf("random%0d", k), int'($urandom_range(1, 8)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 0);
        end
    endtask

    task automatic test_memory;
        int bad = 0;
        for (int i = 0; i < 16; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL memory_image: got %0d differing words required 0", bad);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i] = '0;
            ref_mem[i] = '0;
        end
        test_reset;
        test_basic;
        test_throttled;
        test_boundaries;
        test_reset_mid_load;
        test_busy_start_reload;
        test_random;
        test_memory;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
